// File: rtl/layer_stream_packer.sv
// layer_stream_packer: collects layer-tagged stubs for one event into six
// per-layer buffers, then on end-of-event emits the framed stream
// (header, cumulative counts, stubs grouped by layer, trailer) one word
// per rd_en with a one-cycle registered read latency.
// Optional build macro: PACKER_OVF_CNT_EN adds a saturating 8-bit
// dropped-stub counter output ovf_cnt.
module layer_stream_packer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] stub_in,
  input  logic [2:0]  stub_layer,
  input  logic        stub_valid,
  input  logic        evt_end,
  input  logic [7:0]  bx_in,
  output logic        in_ready,
  input  logic        rd_en,
  output logic [35:0] stream_out,
  output logic        stream_valid,
`ifdef PACKER_OVF_CNT_EN
  output logic        ovf,
  output logic [7:0]  ovf_cnt
`else
  output logic        ovf
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] NO_LAYER = 3'd6;

  typedef enum logic [2:0] {COLLECT, HEADER, COUNTS, STUBS, TRAILER} state_t;

  state_t        state;
  logic [CW-1:0] cnt [6];
  logic [35:0]   stub_buf [6][DEPTH];
  logic [7:0]    bx;
  logic [2:0]    rd_layer;
  logic [CW-1:0] rd_idx;

  logic [5:0]    cum [7];
  logic [2:0]    first_layer;
  logic [2:0]    next_layer;
  logic [CW-1:0] cur_cnt;
  logic [35:0]   cur_stub;
  logic [5:0]    accept;
  logic          drop;

  // Cumulative counts, drain pointer lookups and the stub accept/drop decision.
  always_comb begin
    cum[0]      = '0;
    first_layer = NO_LAYER;
    next_layer  = NO_LAYER;
    cur_cnt     = '0;
    cur_stub    = '0;
    accept      = '0;
    for (int k = 0; k < 6; k++) begin
      cum[k+1] = cum[k] + 6'(cnt[k]);
    end
    for (int l = 5; l >= 0; l--) begin
      if (cnt[l] != '0) begin
        first_layer = 3'(l);
        if (3'(l) > rd_layer) begin
          next_layer = 3'(l);
        end
      end
    end
    for (int l = 0; l < 6; l++) begin
      if (rd_layer == 3'(l)) begin
        cur_cnt = cnt[l];
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_idx == CW'(i)) begin
            cur_stub = stub_buf[l][i];
          end
        end
      end
      if (state == COLLECT && stub_valid && stub_layer == 3'(l) && cnt[l] < CW'(DEPTH)) begin
        accept[l] = 1'b1;
      end
    end
    drop = (state == COLLECT) && stub_valid && (accept == '0);
  end

  // Stub storage: write the accepted stub into the next free slot of its layer.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 6; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (accept[l] && cnt[l] == CW'(i)) begin
          stub_buf[l][i] <= stub_in;
        end
      end
    end
  end

  // Main FSM: collection, then one stream word per rd_en until the trailer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= COLLECT;
      bx           <= '0;
      in_ready     <= 1'b1;
      stream_out   <= '0;
      stream_valid <= 1'b0;
      ovf          <= 1'b0;
      rd_layer     <= '0;
      rd_idx       <= '0;
      for (int l = 0; l < 6; l++) begin
        cnt[l] <= '0;
      end
`ifdef PACKER_OVF_CNT_EN
      ovf_cnt <= '0;
`endif
    end else begin
      stream_valid <= 1'b0;
      if (drop) begin
        ovf <= 1'b1;
`ifdef PACKER_OVF_CNT_EN
        if (ovf_cnt != 8'hFF) begin
          ovf_cnt <= ovf_cnt + 8'd1;
        end
`endif
      end
      case (state)
        COLLECT: begin
          for (int l = 0; l < 6; l++) begin
            if (accept[l]) begin
              cnt[l] <= cnt[l] + 1'b1;
            end
          end
          if (evt_end) begin
            bx       <= bx_in;
            in_ready <= 1'b0;
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (rd_en) begin
            stream_out   <= {3'b111, bx, 25'h1FFFFFF};
            stream_valid <= 1'b1;
            state        <= COUNTS;
          end
        end
        COUNTS: begin
          if (rd_en) begin
            stream_out   <= {cum[1], cum[2], cum[3], cum[4], cum[5], cum[6]};
            stream_valid <= 1'b1;
            rd_layer     <= first_layer;
            rd_idx       <= '0;
            state        <= (cum[6] != '0) ? STUBS : TRAILER;
          end
        end
        STUBS: begin
          if (rd_en) begin
            stream_out   <= cur_stub;
            stream_valid <= 1'b1;
            if (CW'(rd_idx + 1'b1) == cur_cnt) begin
              rd_idx   <= '0;
              rd_layer <= next_layer;
              if (next_layer == NO_LAYER) begin
                state <= TRAILER;
              end
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        TRAILER: begin
          if (rd_en) begin
            stream_out   <= {3'b111, bx, 25'h0};
            stream_valid <= 1'b1;
            in_ready     <= 1'b1;
            state        <= COLLECT;
            for (int l = 0; l < 6; l++) begin
              cnt[l] <= '0;
            end
          end
        end
        default: begin
          state    <= COLLECT;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/layer_stream_packer.md
Name: layer_stream_packer

Overview:
- Upstream neighbour of the disk/layer stub router.
- Collects stubs for one event, each tagged with a layer index 0..5, into six per-layer buffers.
- On end-of-event it emits the framed word stream the router consumes: a header word, a cumulative-counts word, the stubs grouped by layer (layer 0 first), then a trailer word.
- Output is pulled one word per `rd_en`, with a one-cycle registered read latency (memory-like).

Parameters:
- `DEPTH`, 8: stubs stored per layer. Legal range 1..10, so that 6*`DEPTH` ≤ 63 fits a 6-bit cumulative count.

Ports:
- `clk`  in  1  single processing clock.
- `reset`  in  1  synchronous, active-high reset.
- `stub_in`  in  36  stub word.
- `stub_layer`  in  3  layer index of `stub_in`; values 0..5 are valid.
- `stub_valid`  in  1  `stub_in`/`stub_layer` are valid this cycle.
- `evt_end`  in  1  closes the current event.
- `bx_in`  in  8  bunch-crossing number of the closing event; sampled with `evt_end`.
- `in_ready`  out  1  packer accepts `stub_valid`/`evt_end`.
- `rd_en`  in  1  consumer pops one stream word.
- `stream_out`  out  36  registered stream word.
- `stream_valid`  out  1  `stream_out` was updated this cycle.
- `ovf`  out  1  sticky: a stub was dropped.

Behaviour:
- Reset values:
  - State `COLLECT`; all six layer counts 0; stored bx 0.
  - `in_ready`=1, `stream_out`=0, `stream_valid`=0, `ovf`=0.
- States: `COLLECT`, `HEADER`, `COUNTS`, `STUBS`, `TRAILER`.
- `in_ready`=1 only in `COLLECT`. `stub_valid`/`evt_end` are ignored while `in_ready`=0; the source holds them.
- `COLLECT`:
  - `stub_valid` with layer L<6 and cnt[L]<`DEPTH` writes `buf[L][cnt[L]]` and increments cnt[L].
  - L≥6, or cnt[L]=`DEPTH`: stub dropped, `ovf` set.
  - `evt_end`: latch `bx_in`, go to `HEADER` next cycle.
  - `stub_valid` and `evt_end` in the same cycle: the stub belongs to the closing event.
- Pop rule:
  - In any non-`COLLECT` state, `rd_en`=1 loads the current word into `stream_out`.
  - `stream_valid`=1 on the following cycle, then the state advances.
  - `rd_en`=0: `stream_out` holds, `stream_valid`=0.
  - `rd_en` in `COLLECT` has no effect.
- `HEADER` word: [35:33]=3'b111, [32:25]=bx, [24:0]=25'h1FFFFFF. Next state `COUNTS`.
- `COUNTS` word:
  - Cumulative counts C1..C6, with Ck = cnt[0]+…+cnt[k-1], 6 bits each.
  - Packed C1 at [35:30], C2 [29:24], C3 [23:18], C4 [17:12], C5 [11:6], C6 [5:0].
  - Next state `STUBS` if C6>0, else `TRAILER`.
- `STUBS`:
  - Pops `buf[0][0..cnt0-1]`, then layer 1, and so on; empty layers are skipped with no idle slot.
  - Exactly C6 words.
  - After the last stub pop, next state `TRAILER`.
- `TRAILER` word: [35:33]=3'b111, [32:25]=bx, [24:0]=0. After the pop:
  - All cnt cleared.
  - State `COLLECT`, `in_ready`=1 on the next cycle.
- Latency:
  - `evt_end` at cycle t gives `in_ready`=0 at t+1.
  - The first `rd_en` at t+1 or later gives the header on `stream_out` one cycle later.
  - Back-to-back `rd_en` gives one word per cycle.
- Empty event: exactly 3 words — header, counts=0, trailer.
- Reset mid-drain: immediate return to reset values; the partial event is discarded.
- Stub contents are passed unmodified. Stubs matching the header/trailer patterns are not filtered.

Optional Feature:
- `PACKER_OVF_CNT_EN` defined:
  - Adds output `ovf_cnt` [7:0], reset 0.
  - Increments once per dropped stub; saturates at 255.
  - Cleared only by `reset`.
- Not defined: port absent; only the sticky `ovf` is present.

Test Plan:
- 3 stubs (A,B,C) on layer 0, 2 stubs (D,E) on layer 3, `evt_end` with `bx_in`=8'h05, `rd_en` held high -> 8 consecutive `stream_valid` words:
  - 36'hE0BFFFFFF header.
  - Counts C1..C6 = 3,3,3,5,5,5, i.e. 36'h0C30C5145.
  - A, B, C, D, E.
  - 36'hE0A000000 trailer.
  - `in_ready` returns to 1.
- Empty event, `bx_in`=8'hFF -> 3 words: 36'hFFFFFFFFF, 36'h000000000, 36'hFFE000000.
- 9 stubs to layer 5 (`DEPTH`=8), plus one stub with `stub_layer`=6 -> C6=8; `ovf`=1; `ovf_cnt`=2 when `PACKER_OVF_CNT_EN` is defined.
- `stub_valid`+`evt_end` in the same cycle, plus `rd_en` gaps (1,0,0,1,…) -> stub included in the event; `stream_out` holds during gaps; no word lost or duplicated.
- `reset` asserted during `STUBS` -> next cycle `stream_valid`=0, `in_ready`=1; the following event's counts word reflects only new stubs.
- Stubs offered while draining (`in_ready`=0) -> ignored; next event unaffected; `ovf` stays 0.
